issue_buffer: RTL and testbench

Dual-ported instruction queue between decode and `LAUNCH_SELECT`. It accepts up to two decoded instructions per cycle and presents the two oldest entries as `in1`/`in2` with `receive_flag1`/`receive_flag2`. It retires entries according to the `launch_flag` returned that cycle. On a redirect it flushes all entries.

---
 rtl/issue_buffer.sv | 174 +++++++++++++++++
 tb/tb_issue_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_buffer.sv
// issue_buffer: dual-ported instruction queue between decode and the launch
// stage. It accepts up to two decoded instructions per cycle and presents
// the two oldest entries. It retires entries according to the launch result
// returned in the same cycle. A flush discards every entry.
// Optional build macro: ISSUE_BUF_PERF_EN adds three saturating
// performance counters (perf_dual, perf_single, perf_starve).
module issue_buffer #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 67
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               enq_valid,
    input  logic [PC_W-1:0]          enq1_pc,
    input  logic [PC_W-1:0]          enq1_npc,
    input  logic [DC_W-1:0]          enq1_decodeout,
    input  logic [PC_W-1:0]          enq2_pc,
    input  logic [PC_W-1:0]          enq2_npc,
    input  logic [DC_W-1:0]          enq2_decodeout,
    output logic                     enq_ready,
    input  logic [3:0]               launch_flag,
    input  logic                     flush,
    output logic [PC_W-1:0]          out1_pc,
    output logic [PC_W-1:0]          out1_npc,
    output logic [DC_W-1:0]          out1_decodeout,
    output logic                     receive_flag1,
    output logic [PC_W-1:0]          out2_pc,
    output logic [PC_W-1:0]          out2_npc,
    output logic [DC_W-1:0]          out2_decodeout,
    output logic                     receive_flag2,
    output logic [$clog2(DEPTH):0]   count
`ifdef ISSUE_BUF_PERF_EN
    ,
    output logic [31:0]              perf_dual,
    output logic [31:0]              perf_single,
    output logic [31:0]              perf_starve
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PC_W + DC_W;

    // Entry layout: {pc, npc, decodeout}
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_iss1;
    logic            w_iss2;
    logic [1:0]      w_pop_raw;
    logic [1:0]      w_pop;
    logic [1:0]      w_enq;
    logic [AW-1:0]   w_rd_ptr1;
    logic [AW-1:0]   w_wr_ptr1;
    logic [EW-1:0]   w_head;
    logic [EW-1:0]   w_next;
    logic [EW-1:0]   w_slot1;
    logic [EW-1:0]   w_slot2;

    assign w_rd_ptr1 = r_rd_ptr + AW'(1);
    assign w_wr_ptr1 = r_wr_ptr + AW'(1);

    // Ready looks only at the registered count so launch_flag stays off this path
    assign enq_ready = (r_count <= CW'(DEPTH - 2));

    assign w_iss1 = launch_flag[3] | launch_flag[2];
    assign w_iss2 = launch_flag[1] | launch_flag[0];

    assign w_slot1 = {enq1_pc, enq1_npc, enq1_decodeout};
    assign w_slot2 = {enq2_pc, enq2_npc, enq2_decodeout};

    // Pop and enqueue amounts; head+1 never retires without the head
    always_comb begin
        w_pop_raw = 2'd0;
        if (w_iss1) begin
            w_pop_raw = w_iss2 ? 2'd2 : 2'd1;
        end
        w_pop = w_pop_raw;
        if ({{(CW-2){1'b0}}, w_pop_raw} > r_count) begin
            w_pop = r_count[1:0];
        end
        w_enq = 2'd0;
        if (enq_ready && enq_valid[0]) begin
            w_enq = enq_valid[1] ? 2'd2 : 2'd1;
        end
    end

    // Pointer and occupancy state; flush overrides any same-cycle pop/enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_wr_ptr <= r_wr_ptr + AW'(w_enq);
            r_count  <= r_count + CW'(w_enq) - CW'(w_pop);
        end
    end

    // Storage writes; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (rst_n && !flush && (w_enq != 2'd0)) begin
            r_mem[r_wr_ptr] <= w_slot1;
            if (w_enq == 2'd2) begin
                r_mem[w_wr_ptr1] <= w_slot2;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign w_next = r_mem[w_rd_ptr1];

    assign receive_flag1 = (r_count >= CW'(1));
    assign receive_flag2 = (r_count >= CW'(2));
    assign count         = r_count;

    // Read-side fields, forced to zero when the matching entry is absent
    always_comb begin
        out1_pc        = '0;
        out1_npc       = '0;
        out1_decodeout = '0;
        out2_pc        = '0;
        out2_npc       = '0;
        out2_decodeout = '0;
        if (receive_flag1) begin
            out1_pc        = w_head[EW-1 -: PC_W];
            out1_npc       = w_head[DC_W +: PC_W];
            out1_decodeout = w_head[DC_W-1:0];
        end
        if (receive_flag2) begin
            out2_pc        = w_next[EW-1 -: PC_W];
            out2_npc       = w_next[DC_W +: PC_W];
            out2_decodeout = w_next[DC_W-1:0];
        end
    end

`ifdef ISSUE_BUF_PERF_EN
    logic [31:0] r_perf_dual;
    logic [31:0] r_perf_single;
    logic [31:0] r_perf_starve;

    // Saturating utilisation counters; a flush does not clear them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_dual   <= '0;
            r_perf_single <= '0;
            r_perf_starve <= '0;
        end else begin
            if ((w_pop == 2'd2) && (r_perf_dual != '1)) begin
                r_perf_dual <= r_perf_dual + 32'd1;
            end
            if ((w_pop == 2'd1) && (r_perf_single != '1)) begin
                r_perf_single <= r_perf_single + 32'd1;
            end
            if ((r_count == '0) && !flush && (r_perf_starve != '1)) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_dual   = r_perf_dual;
    assign perf_single = r_perf_single;
    assign perf_starve = r_perf_starve;
`endif

endmodule

// File: tb/tb_issue_buffer.sv
// Directed testbench for issue_buffer (default build, DEPTH=8).
module tb_issue_buffer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  enq_valid;
    logic [31:0] enq1_pc, enq1_npc, enq2_pc, enq2_npc;
    logic [66:0] enq1_decodeout, enq2_decodeout;
    logic        enq_ready;
    logic [3:0]  launch_flag;
    logic        flush;
    logic [31:0] out1_pc, out1_npc, out2_pc, out2_npc;
    logic [66:0] out1_decodeout, out2_decodeout;
    logic        receive_flag1, receive_flag2;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    issue_buffer #(.DEPTH(8), .PC_W(32), .DC_W(67)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enq_valid      (enq_valid),
        .enq1_pc        (enq1_pc),
        .enq1_npc       (enq1_npc),
        .enq1_decodeout (enq1_decodeout),
        .enq2_pc        (enq2_pc),
        .enq2_npc       (enq2_npc),
        .enq2_decodeout (enq2_decodeout),
        .enq_ready      (enq_ready),
        .launch_flag    (launch_flag),
        .flush          (flush),
        .out1_pc        (out1_pc),
        .out1_npc       (out1_npc),
        .out1_decodeout (out1_decodeout),
        .receive_flag1  (receive_flag1),
        .out2_pc        (out2_pc),
        .out2_npc       (out2_npc),
        .out2_decodeout (out2_decodeout),
        .receive_flag2  (receive_flag2),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [66:0] mkdec(input logic [31:0] pc);
        return {3'b101, 32'hA5A5_0000, pc};
    endfunction

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; inputs return to idle afterwards
    task automatic cyc(input logic [1:0] ev, input logic [31:0] p1, input logic [31:0] p2,
                       input logic [3:0] lf, input logic fl);
        enq_valid      = ev;
        enq1_pc        = p1;
        enq1_npc       = p1 + 32'd4;
        enq1_decodeout = mkdec(p1);
        enq2_pc        = p2;
        enq2_npc       = p2 + 32'd4;
        enq2_decodeout = mkdec(p2);
        launch_flag    = lf;
        flush          = fl;
        @(posedge clk);
        #1;
        $display("cyc ev=%b lf=%b fl=%b -> count=%0d f1=%b f2=%b out1=%0h out2=%0h rdy=%b",
                 ev, lf, fl, count, receive_flag1, receive_flag2, out1_pc, out2_pc, enq_ready);
        enq_valid   = 2'b00;
        launch_flag = 4'b0000;
        flush       = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        int n;
        int h;
        base = 32'h1000;
        rst_n = 1'b1;
        enq_valid = 2'b00; launch_flag = 4'b0000; flush = 1'b0;
        enq1_pc = '0; enq1_npc = '0; enq1_decodeout = '0;
        enq2_pc = '0; enq2_npc = '0; enq2_decodeout = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 67'(count), 67'd0);
        chk("rst_f1", 67'(receive_flag1), 67'd0);
        chk("rst_f2", 67'(receive_flag2), 67'd0);
        chk("rst_out1", 67'(out1_pc), 67'd0);
        chk("rst_ready", 67'(enq_ready), 67'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Dual enqueue into empty buffer
        cyc(2'b11, 32'h100, 32'h104, 4'b0000, 1'b0);
        chk("enq2_count", 67'(count), 67'd2);
        chk("enq2_f1", 67'(receive_flag1), 67'd1);
        chk("enq2_f2", 67'(receive_flag2), 67'd1);
        chk("enq2_out1pc", 67'(out1_pc), 67'h100);
        chk("enq2_out2pc", 67'(out2_pc), 67'h104);
        chk("enq2_out1npc", 67'(out1_npc), 67'h104);
        chk("enq2_out2dec", out2_decodeout, mkdec(32'h104));

        // Dual pop empties it
        cyc(2'b00, 32'h0, 32'h0, 4'b0110, 1'b0);
        chk("pop2_count", 67'(count), 67'd0);
        chk("pop2_f1", 67'(receive_flag1), 67'd0);
        chk("pop2_f2", 67'(receive_flag2), 67'd0);
        chk("pop2_out1", 67'(out1_pc), 67'd0);
        chk("pop2_out2", 67'(out2_pc), 67'd0);

        // Single pop
        cyc(2'b11, 32'h100, 32'h104, 4'b0000, 1'b0);
        cyc(2'b00, 32'h0, 32'h0, 4'b0100, 1'b0);
        chk("pop1_count", 67'(count), 67'd1);
        chk("pop1_out1", 67'(out1_pc), 67'h104);
        chk("pop1_f2", 67'(receive_flag2), 67'd0);
        chk("pop1_out2", 67'(out2_pc), 67'd0);

        // head+1 issue alone retires nothing
        cyc(2'b00, 32'h0, 32'h0, 4'b0011, 1'b0);
        chk("iss2only_count", 67'(count), 67'd1);
        chk("iss2only_out1", 67'(out1_pc), 67'h104);

        // Pop 2 with one entry clamps to 1, then pop on empty stays empty
        cyc(2'b00, 32'h0, 32'h0, 4'b1111, 1'b0);
        chk("clamp_count", 67'(count), 67'd0);
        cyc(2'b00, 32'h0, 32'h0, 4'b1111, 1'b0);
        chk("empty_pop_count", 67'(count), 67'd0);
        chk("empty_pop_f1", 67'(receive_flag1), 67'd0);

        // Fill to DEPTH-1
        cyc(2'b11, 32'h200, 32'h204, 4'b0000, 1'b0);
        cyc(2'b11, 32'h208, 32'h20C, 4'b0000, 1'b0);
        cyc(2'b11, 32'h210, 32'h214, 4'b0000, 1'b0);
        chk("fill6_count", 67'(count), 67'd6);
        chk("fill6_ready", 67'(enq_ready), 67'd1);
        cyc(2'b01, 32'h218, 32'h0, 4'b0000, 1'b0);
        chk("fill7_count", 67'(count), 67'd7);
        chk("fill7_ready", 67'(enq_ready), 67'd0);
        cyc(2'b11, 32'h300, 32'h304, 4'b0000, 1'b0);
        chk("full_ignore_count", 67'(count), 67'd7);
        chk("full_out1", 67'(out1_pc), 67'h200);
        cyc(2'b00, 32'h0, 32'h0, 4'b1010, 1'b0);
        chk("drain_count", 67'(count), 67'd5);
        chk("drain_ready", 67'(enq_ready), 67'd1);
        chk("drain_out1", 67'(out1_pc), 67'h208);
        chk("drain_out2", 67'(out2_pc), 67'h20C);

        // Flush beats simultaneous enqueue and pop
        cyc(2'b11, 32'h400, 32'h404, 4'b1001, 1'b1);
        chk("flush_count", 67'(count), 67'd0);
        chk("flush_f1", 67'(receive_flag1), 67'd0);
        chk("flush_out1", 67'(out1_pc), 67'd0);
        cyc(2'b10, 32'h500, 32'h504, 4'b0000, 1'b0);
        chk("slot2only_count", 67'(count), 67'd0);
        cyc(2'b11, 32'h600, 32'h604, 4'b0000, 1'b0);
        chk("postflush_out1", 67'(out1_pc), 67'h600);
        chk("postflush_out2", 67'(out2_pc), 67'h604);
        cyc(2'b00, 32'h0, 32'h0, 4'b0110, 1'b0);
        chk("postflush_clear", 67'(count), 67'd0);

        // Streaming enq 2 / pop 2 wraps both pointers
        cyc(2'b11, base, base + 32'd4, 4'b0000, 1'b0);
        n = 2;
        h = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(2'b11, base + 32'(4 * n), base + 32'(4 * n + 4), 4'b1010, 1'b0);
            n += 2;
            h += 2;
            chk("wrap_count", 67'(count), 67'd2);
            chk("wrap_out1", 67'(out1_pc), 67'(base + 32'(4 * h)));
            chk("wrap_out2", 67'(out2_pc), 67'(base + 32'(4 * h + 4)));
        end

        // Pop 2 + enq 2 at DEPTH-2 keeps count steady
        cyc(2'b11, base + 32'(4 * n), base + 32'(4 * n + 4), 4'b0000, 1'b0);
        n += 2;
        cyc(2'b11, base + 32'(4 * n), base + 32'(4 * n + 4), 4'b0000, 1'b0);
        n += 2;
        chk("d2_pre_count", 67'(count), 67'd6);
        cyc(2'b11, base + 32'(4 * n), base + 32'(4 * n + 4), 4'b1100, 1'b0);
        chk("d2_pop1_count", 67'(count), 67'd7);
        n += 2;
        h += 1;
        chk("d2_out1", 67'(out1_pc), 67'(base + 32'(4 * h)));
        chk("d2_ready", 67'(enq_ready), 67'd0);
        cyc(2'b00, 32'h0, 32'h0, 4'b0100, 1'b0);
        h += 1;
        chk("d2_back6", 67'(count), 67'd6);
        cyc(2'b11, base + 32'(4 * n), base + 32'(4 * n + 4), 4'b0101, 1'b0);
        n += 2;
        h += 2;
        chk("d2_steady_count", 67'(count), 67'd6);
        chk("d2_steady_out1", 67'(out1_pc), 67'(base + 32'(4 * h)));
        chk("d2_steady_out2", 67'(out2_pc), 67'(base + 32'(4 * h + 4)));

        // Asynchronous reset in the middle of operation
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 67'(count), 67'd0);
        chk("midrst_f1", 67'(receive_flag1), 67'd0);
        chk("midrst_out1", 67'(out1_pc), 67'd0);
        chk("midrst_ready", 67'(enq_ready), 67'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b00, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("postrst_count", 67'(count), 67'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
